syscall_console: RTL and testbench

//  Downstream consumer of the system/syscall stage. Takes issued instructions (ID, rs, rt) after decode.
//  For syscall: buffers print requests in a FIFO, drains them to a console sink over a valid/ready handshake,
//  and sequences program exit (drain all buffered output, then assert done). Non-syscall IDs pass untouched.

---
 rtl/syscall_console_if.sv | 32 +++
 rtl/syscall_console.sv | 124 ++++++++++++
 tb/tb_syscall_console.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/syscall_console_if.sv
// Syscall console bus: instruction issue from decode, print-word stream to the
// console sink, and exit/error status back to the core.
interface syscall_console_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             issue;
    logic [31:0]      ID;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             stall;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             halted;
    logic             done;
    logic             err_svc;
    logic [CNT_W-1:0] emit_cnt;
    logic [1:0]       dbg_state;

    // Handshake: a console word transfers on every rising edge where
    // out_valid && out_ready; out_data is held stable while out_valid && !out_ready.
    modport master (
        output issue, ID, rs, rt, out_ready,
        input  stall, out_valid, out_data, halted, done, err_svc, emit_cnt, dbg_state
    );

    modport slave (
        input  issue, ID, rs, rt, out_ready,
        output stall, out_valid, out_data, halted, done, err_svc, emit_cnt, dbg_state
    );
endinterface

// File: rtl/syscall_console.sv
// Syscall console: buffers print syscalls in a FIFO, streams them to a sink,
// and sequences program exit (drain buffered output, then report done).
module syscall_console #(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 32,
    parameter int SYSCALL_ID = 26,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               reset,
    syscall_console_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_halted;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_emit;

    logic w_syscall;
    logic w_print;
    logic w_exit;
    logic w_bad_svc;
    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    assign w_syscall = bus.issue && (bus.ID == 32'(SYSCALL_ID)) && (r_state == S_RUN);
    assign w_print   = w_syscall && (bus.rs == WIDTH'(1));
    assign w_exit    = w_syscall && (bus.rs == WIDTH'(2));
    assign w_bad_svc = w_syscall && (bus.rs != WIDTH'(1)) && (bus.rs != WIDTH'(2))
                       && (bus.rs != WIDTH'(3));
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_valid   = (r_count != '0);
    // Fullness uses the pre-edge count, so a same-cycle pop never frees a slot.
    assign w_push    = w_print && !w_full;
    assign w_pop     = w_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_emit   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_emit != '1) begin
                    r_emit <= r_emit + 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_bad_svc) begin
                r_err <= 1'b1;
            end
        end
    end

    // Exit sequencing; halted/done are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_exit) begin
                        r_state  <= S_DRAIN;
                        r_halted <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign bus.stall     = w_print && w_full;
    assign bus.out_valid = w_valid;
    // An empty FIFO presents zero rather than a stale or uninitialised slot.
    assign bus.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.halted    = r_halted;
    assign bus.done      = r_done;
    assign bus.err_svc   = r_err;
    assign bus.emit_cnt  = r_emit;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_syscall_console.sv
// Bench for syscall_console: directed syscall sequences, a scoreboard of expected
// console words popped by a monitor, and direct status checks.
module tb_syscall_console;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;
    localparam int SYS   = 26;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    logic [WIDTH-1:0] exp_q [$];

    syscall_console_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    syscall_console #(
        .DEPTH(8), .WIDTH(WIDTH), .SYSCALL_ID(SYS), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every word the sink accepts must be the next expected word.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sink_word: got %0d with no word expected", bus.out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    n_fail++;
                    $display("FAIL sink_word: got %0d expected %0d", bus.out_data, e);
                end
            end
        end
    end

    // Driver: one-cycle issue; stall checked mid-cycle; accepted prints go to the scoreboard.
    task automatic issue_cycle(input logic [31:0] id, input logic [WIDTH-1:0] rs,
                               input logic [WIDTH-1:0] rt, input logic exp_stall,
                               input logic exp_push);
        @(posedge clk);
        #1;
        bus.issue = 1'b1;
        bus.ID    = id;
        bus.rs    = rs;
        bus.rt    = rt;
        @(negedge clk);
        check("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
        if (exp_push) exp_q.push_back(rt);
        @(posedge clk);
        #1;
        bus.issue = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},    {31'd0, bus.stall},     0);
        check({tag, "_valid"},    {31'd0, bus.out_valid}, 0);
        check({tag, "_data"},     bus.out_data,           0);
        check({tag, "_halted"},   {31'd0, bus.halted},    0);
        check({tag, "_done"},     {31'd0, bus.done},      0);
        check({tag, "_err"},      {31'd0, bus.err_svc},   0);
        check({tag, "_emit"},     {16'd0, bus.emit_cnt},  0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.issue = 1'b0;
        bus.ID    = '0;
        bus.rs    = '0;
        bus.rt    = '0;
        bus.out_ready = 1'b0;

        // T1: reset, single print with sink ready
        pulse_reset();
        check_all_zero("t1_reset");
        bus.out_ready = 1'b1;
        issue_cycle(SYS, 1, 1001, 1'b0, 1'b1);
        check("t1_valid", {31'd0, bus.out_valid}, 1);
        check("t1_data", bus.out_data, 1001);
        @(posedge clk);
        #1;
        check("t1_emit", {16'd0, bus.emit_cnt}, 1);
        check("t1_empty", {31'd0, bus.out_valid}, 0);

        // T2: fill with sink blocked, 9th print stalls, then drain with wrap
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            issue_cycle(SYS, 1, i, (i == 9), (i <= 8));
        end
        check("t2_held", bus.out_data, 1);
        bus.out_ready = 1'b1;
        wait_drain("t2_drain");
        @(posedge clk);
        #1;
        check("t2_emit", {16'd0, bus.emit_cnt}, 9);

        // T3: non-syscall and nop syscall leave everything alone
        issue_cycle(14, 10, 100, 1'b0, 1'b0);
        issue_cycle(SYS, 3, 55, 1'b0, 1'b0);
        check("t3_valid", {31'd0, bus.out_valid}, 0);
        check("t3_err", {31'd0, bus.err_svc}, 0);
        check("t3_halted", {31'd0, bus.halted}, 0);

        // T4: exit with buffered words; print in DRAIN dropped
        bus.out_ready = 1'b0;
        issue_cycle(SYS, 1, 11, 1'b0, 1'b1);
        issue_cycle(SYS, 1, 12, 1'b0, 1'b1);
        issue_cycle(SYS, 1, 13, 1'b0, 1'b1);
        issue_cycle(SYS, 2, 0, 1'b0, 1'b0);
        check("t4_halted", {31'd0, bus.halted}, 1);
        check("t4_not_done", {31'd0, bus.done}, 0);
        issue_cycle(SYS, 1, 99, 1'b0, 1'b0);
        check("t4_head", bus.out_data, 11);
        bus.out_ready = 1'b1;
        wait_drain("t4_drain");
        repeat (3) @(posedge clk);
        #1;
        check("t4_done", {31'd0, bus.done}, 1);
        check("t4_emit", {16'd0, bus.emit_cnt}, 12);

        // T5: unknown service sets sticky error
        pulse_reset();
        check("t5_rst_done", {31'd0, bus.done}, 0);
        issue_cycle(SYS, 7, 0, 1'b0, 1'b0);
        check("t5_err", {31'd0, bus.err_svc}, 1);
        check("t5_valid", {31'd0, bus.out_valid}, 0);
        issue_cycle(SYS, 1, 5, 1'b0, 1'b1);
        wait_drain("t5_drain");
        check("t5_err_sticky", {31'd0, bus.err_svc}, 1);

        // T6: reset mid-drain discards buffered words
        bus.out_ready = 1'b0;
        issue_cycle(SYS, 1, 21, 1'b0, 1'b1);
        issue_cycle(SYS, 1, 22, 1'b0, 1'b1);
        issue_cycle(SYS, 2, 0, 1'b0, 1'b0);
        check("t6_halted", {31'd0, bus.halted}, 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        issue_cycle(SYS, 1, 31, 1'b0, 1'b1);
        wait_drain("t6_drain");
        @(posedge clk);
        #1;
        check("t6_emit", {16'd0, bus.emit_cnt}, 1);

        check("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
